// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types for the RAM arbiter
// Purpose: lock FSM state encoding and requester identifiers used by the
//          arbiter top and its round-robin sub-module.
package ram_arbiter_pkg;

   // ST_ARB: normal round-robin sharing; ST_LOCK_B: B owns the RAM exclusively
   typedef enum logic {
      ST_ARB    = 1'b0,
      ST_LOCK_B = 1'b1
   } state_e;

   // Requester identity; the numeric value is also the bit index in req/gnt vectors
   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way combinational round-robin grant
// Purpose: grant at most one of two requesters; on contention the requester
//          that did not win last time gets the grant.
// Ports:
//   req_i[1:0]    request vector (bit 0 = A, bit 1 = B)
//   last_grant_i  requester that won the most recent transfer
//   gnt_o[1:0]    one-hot (or zero) grant vector
module rr_arbiter2
   import ram_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  req_id_e    last_grant_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && req_i[1]) begin
         if (last_grant_i == REQ_B) begin
            gnt_o[0] = 1'b1;
         end else begin
            gnt_o[1] = 1'b1;
         end
      end else begin
         gnt_o = req_i;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one RAM between instruction fetch (A) and load/store (B)
// Purpose: round-robin arbitration of one access per cycle, tagged read responses
//          one cycle after the grant, and an exclusive bounded lock for B.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   a_req/a_addr/a_ready           A read request channel
//   a_rvalid/a_rdata               A read response
//   b_req/b_we/b_lock/b_addr/
//   b_wdata/b_ready                B read/write request channel with lock
//   b_rvalid/b_rdata               B read response
//   ram_write_en/ram_write_adress/
//   ram_data_in                    RAM write port
//   ram_rd_en/ram_rd_adress        RAM read port
//   ram_data_out                   RAM registered read data
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int DATA_SIZE = 8,
   parameter int MAX_LOCK  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 a_req,
   input  logic [ADDR_SIZE-1:0] a_addr,
   output logic                 a_ready,
   output logic                 a_rvalid,
   output logic [DATA_SIZE-1:0] a_rdata,
   input  logic                 b_req,
   input  logic                 b_we,
   input  logic                 b_lock,
   input  logic [ADDR_SIZE-1:0] b_addr,
   input  logic [DATA_SIZE-1:0] b_wdata,
   output logic                 b_ready,
   output logic                 b_rvalid,
   output logic [DATA_SIZE-1:0] b_rdata,
   output logic                 ram_write_en,
   output logic [ADDR_SIZE-1:0] ram_write_adress,
   output logic [DATA_SIZE-1:0] ram_data_in,
   output logic                 ram_rd_en,
   output logic [ADDR_SIZE-1:0] ram_rd_adress,
   input  logic [DATA_SIZE-1:0] ram_data_out
);

   localparam int CNT_W = $clog2(MAX_LOCK);

   state_e             state_q, state_d;
   req_id_e            last_grant_q, last_grant_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic               resp_a_q, resp_a_d;
   logic               resp_b_q, resp_b_d;
   logic [1:0]         arb_gnt;

   rr_arbiter2 u_rr (
      .req_i        ({b_req, a_req}),
      .last_grant_i (last_grant_q),
      .gnt_o        (arb_gnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_ARB;
         last_grant_q <= REQ_B;
         lock_cnt_q   <= '0;
         resp_a_q     <= 1'b0;
         resp_b_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         lock_cnt_q   <= lock_cnt_d;
         resp_a_q     <= resp_a_d;
         resp_b_q     <= resp_b_d;
      end
   end

   // Lock FSM, grants and last-grant tracking
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      lock_cnt_d   = lock_cnt_q;
      a_ready      = 1'b0;
      b_ready      = 1'b0;

      case (state_q)
         ST_ARB: begin
            a_ready = arb_gnt[0];
            b_ready = arb_gnt[1];
            if (b_ready && b_lock) begin
               state_d    = ST_LOCK_B;
               lock_cnt_d = CNT_W'(1);
            end
         end
         ST_LOCK_B: begin
            b_ready    = b_req;
            lock_cnt_d = lock_cnt_q + CNT_W'(1);
            if (lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
               // Forced release: mark B as last winner so A wins the next contest
               state_d      = ST_ARB;
               lock_cnt_d   = '0;
               last_grant_d = REQ_B;
            end else if (!b_lock) begin
               // Covers both "granted with lock dropped" and "idle with lock dropped"
               state_d    = ST_ARB;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = ST_ARB;
            lock_cnt_d = '0;
         end
      endcase

      if (a_ready) begin
         last_grant_d = REQ_A;
      end else if (b_ready) begin
         last_grant_d = REQ_B;
      end

      resp_a_d = a_ready;
      resp_b_d = b_ready && !b_we;
   end

   // RAM port mux; everything is zero when nobody is granted
   always_comb begin
      ram_write_en     = 1'b0;
      ram_write_adress = '0;
      ram_data_in      = '0;
      ram_rd_en        = 1'b0;
      ram_rd_adress    = '0;
      if (a_ready) begin
         ram_rd_en     = 1'b1;
         ram_rd_adress = a_addr;
      end else if (b_ready) begin
         if (b_we) begin
            ram_write_en     = 1'b1;
            ram_write_adress = b_addr;
            ram_data_in      = b_wdata;
         end else begin
            ram_rd_en     = 1'b1;
            ram_rd_adress = b_addr;
         end
      end
   end

   // RAM output is already registered, so the tag flop just steers it
   assign a_rvalid = resp_a_q;
   assign b_rvalid = resp_b_q;
   assign a_rdata  = resp_a_q ? ram_data_out : '0;
   assign b_rdata  = resp_b_q ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

   localparam int ADDR_SIZE = 8;
   localparam int DATA_SIZE = 8;
   localparam int MAX_LOCK  = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 a_req;
   logic [ADDR_SIZE-1:0] a_addr;
   logic                 a_ready;
   logic                 a_rvalid;
   logic [DATA_SIZE-1:0] a_rdata;
   logic                 b_req;
   logic                 b_we;
   logic                 b_lock;
   logic [ADDR_SIZE-1:0] b_addr;
   logic [DATA_SIZE-1:0] b_wdata;
   logic                 b_ready;
   logic                 b_rvalid;
   logic [DATA_SIZE-1:0] b_rdata;
   logic                 ram_write_en;
   logic [ADDR_SIZE-1:0] ram_write_adress;
   logic [DATA_SIZE-1:0] ram_data_in;
   logic                 ram_rd_en;
   logic [ADDR_SIZE-1:0] ram_rd_adress;
   logic [DATA_SIZE-1:0] ram_data_out;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [DATA_SIZE-1:0] m_mem [0:255];
   bit                   m_locked;
   int                   m_age;
   bit                   m_last_a;

   // Environment RAM
   logic [DATA_SIZE-1:0] ram_mem [0:255];
   bit                   ram_init_done = 1'b0;

   function automatic logic [DATA_SIZE-1:0] init_val(int i);
      return DATA_SIZE'(i * 37 + 10);
   endfunction

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!ram_init_done) begin
         for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
         ram_init_done <= 1'b1;
      end else begin
         if (ram_write_en) ram_mem[ram_write_adress] <= ram_data_in;
         if (ram_rd_en) ram_data_out <= ram_mem[ram_rd_adress];
      end
   end

   ram_arbiter #(
      .ADDR_SIZE (ADDR_SIZE),
      .DATA_SIZE (DATA_SIZE),
      .MAX_LOCK  (MAX_LOCK)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .a_req            (a_req),
      .a_addr           (a_addr),
      .a_ready          (a_ready),
      .a_rvalid         (a_rvalid),
      .a_rdata          (a_rdata),
      .b_req            (b_req),
      .b_we             (b_we),
      .b_lock           (b_lock),
      .b_addr           (b_addr),
      .b_wdata          (b_wdata),
      .b_ready          (b_ready),
      .b_rvalid         (b_rvalid),
      .b_rdata          (b_rdata),
      .ram_write_en     (ram_write_en),
      .ram_write_adress (ram_write_adress),
      .ram_data_in      (ram_data_in),
      .ram_rd_en        (ram_rd_en),
      .ram_rd_adress    (ram_rd_adress),
      .ram_data_out     (ram_data_out)
   );

   task automatic model_reset();
      m_locked = 1'b0;
      m_age    = 0;
      m_last_a = 1'b0;
   endtask

   task automatic idle_inputs();
      a_req = 0; a_addr = '0;
      b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // One clock of stimulus: inputs are set by the caller at a falling edge.
   // Grants/RAM port are compared before the rising edge, responses after it.
   task automatic cycle(output bit obs_a, output bit obs_b);
      bit ga, gb, ea_rv, eb_rv;
      logic [DATA_SIZE-1:0] ea_rd, eb_rd;
      logic [1+ADDR_SIZE+DATA_SIZE+1+ADDR_SIZE-1:0] exp_port, got_port;
      #1;
      if (m_locked) begin
         ga = 1'b0; gb = b_req;
      end else if (a_req && b_req) begin
         ga = !m_last_a; gb = m_last_a;
      end else begin
         ga = a_req; gb = b_req;
      end
      checks++;
      if (a_ready !== ga || b_ready !== gb) begin
         failures++;
         $display("FAIL grant t=%0t: got a_ready=%b b_ready=%b expected %b %b", $time, a_ready, b_ready, ga, gb);
      end
      exp_port = '0;
      if (ga) exp_port = {1'b0, ADDR_SIZE'(0), DATA_SIZE'(0), 1'b1, a_addr};
      else if (gb && b_we) exp_port = {1'b1, b_addr, b_wdata, 1'b0, ADDR_SIZE'(0)};
      else if (gb) exp_port = {1'b0, ADDR_SIZE'(0), DATA_SIZE'(0), 1'b1, b_addr};
      got_port = {ram_write_en, ram_write_adress, ram_data_in, ram_rd_en, ram_rd_adress};
      checks++;
      if (got_port !== exp_port) begin
         failures++;
         $display("FAIL ram_port t=%0t: got we/wa/din/re/ra=%h expected %h", $time, got_port, exp_port);
      end
      obs_a = a_ready;
      obs_b = b_ready;

      @(posedge clk);
      ea_rv = ga;
      ea_rd = m_mem[a_addr];
      eb_rv = gb && !b_we;
      eb_rd = m_mem[b_addr];
      if (gb && b_we) m_mem[b_addr] = b_wdata;
      if (ga) m_last_a = 1'b1;
      if (gb) m_last_a = 1'b0;
      if (!m_locked) begin
         if (gb && b_lock) begin
            m_locked = 1'b1;
            m_age    = 1;
         end
      end else if (m_age == MAX_LOCK - 1) begin
         m_locked = 1'b0; m_age = 0; m_last_a = 1'b0;
      end else if (!b_lock) begin
         m_locked = 1'b0; m_age = 0;
      end else begin
         m_age++;
      end

      #1;
      checks++;
      if (a_rvalid !== ea_rv || b_rvalid !== eb_rv) begin
         failures++;
         $display("FAIL rvalid t=%0t: got a=%b b=%b expected a=%b b=%b", $time, a_rvalid, b_rvalid, ea_rv, eb_rv);
      end
      if (ea_rv) begin
         checks++;
         if (a_rdata !== ea_rd) begin
            failures++;
            $display("FAIL a_rdata t=%0t: got %h expected %h", $time, a_rdata, ea_rd);
         end
      end
      if (eb_rv) begin
         checks++;
         if (b_rdata !== eb_rd) begin
            failures++;
            $display("FAIL b_rdata t=%0t: got %h expected %h", $time, b_rdata, eb_rd);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if ({a_ready, b_ready, a_rvalid, b_rvalid, ram_write_en, ram_rd_en} !== 6'b0 ||
          a_rdata !== '0 || b_rdata !== '0 || ram_rd_adress !== '0 || ram_write_adress !== '0) begin
         failures++;
         $display("FAIL reset_state: got rdy=%b%b rv=%b%b we=%b re=%b ard=%h brd=%h expected all zero",
                  a_ready, b_ready, a_rvalid, b_rvalid, ram_write_en, ram_rd_en, a_rdata, b_rdata);
      end
   endtask

   task automatic test_single_read();
      bit oa, ob;
      a_req = 1; a_addr = 8'h10;
      cycle(oa, ob);
      checks++;
      if (oa !== 1'b1 || a_rvalid !== 1'b1 || a_rdata !== 8'h5A) begin
         failures++;
         $display("FAIL single_read: got ready=%b rvalid=%b rdata=%h expected 1 1 5a", oa, a_rvalid, a_rdata);
      end
      idle_inputs();
      cycle(oa, ob);
      checks++;
      if (a_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rvalid_pulse: got a_rvalid=%b expected 0", a_rvalid);
      end
   endtask

   task automatic test_alternate();
      bit oa, ob;
      int n_rv = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         a_req = 1; a_addr = 8'($urandom_range(0, 255));
         b_req = 1; b_we = 0; b_lock = 0; b_addr = 8'h20;
         cycle(oa, ob);
         n_rv += int'(a_rvalid) + int'(b_rvalid);
         checks++;
         if (oa !== ((i % 2) == 0) || ob !== ((i % 2) == 1)) begin
            failures++;
            $display("FAIL alternate[%0d]: got a=%b b=%b expected a=%b", i, oa, ob, (i % 2) == 0);
         end
      end
      idle_inputs();
      checks++;
      if (n_rv != 4) begin
         failures++;
         $display("FAIL alternate_pulses: got %0d expected 4", n_rv);
      end
   endtask

   task automatic test_write_read();
      bit oa, ob;
      b_req = 1; b_we = 1; b_addr = 8'h40; b_wdata = 8'h33;
      cycle(oa, ob);
      b_we = 0;
      cycle(oa, ob);
      checks++;
      if (b_rvalid !== 1'b1 || b_rdata !== 8'h33) begin
         failures++;
         $display("FAIL write_read: got b_rvalid=%b b_rdata=%h expected 1 33", b_rvalid, b_rdata);
      end
      idle_inputs();
   endtask

   task automatic test_lock_rmw();
      bit oa, ob;
      a_req = 1; a_addr = 8'h01;
      cycle(oa, ob);
      b_req = 1; b_we = 0; b_lock = 1; b_addr = 8'h40;
      cycle(oa, ob);
      checks++;
      if (oa !== 1'b0 || ob !== 1'b1) begin
         failures++;
         $display("FAIL lock_read: got a=%b b=%b expected a=0 b=1", oa, ob);
      end
      b_we = 1; b_lock = 0; b_addr = 8'h41; b_wdata = b_rdata + 8'h1;
      cycle(oa, ob);
      checks++;
      if (oa !== 1'b0 || ob !== 1'b1) begin
         failures++;
         $display("FAIL lock_write: got a=%b b=%b expected a=0 b=1", oa, ob);
      end
      b_req = 0; b_we = 0;
      cycle(oa, ob);
      checks++;
      if (oa !== 1'b1) begin
         failures++;
         $display("FAIL lock_release: got a_ready=%b expected 1", oa);
      end
      idle_inputs();
   endtask

   task automatic test_lock_timeout();
      bit oa, ob, seen_a = 1'b0;
      int n_b = 0;
      a_req = 1; a_addr = 8'h02;
      cycle(oa, ob);
      for (int i = 0; i < 20 && !seen_a; i++) begin
         b_req = 1; b_lock = 1; b_we = 0; b_addr = 8'($urandom_range(0, 255));
         a_addr = 8'($urandom_range(0, 255));
         cycle(oa, ob);
         if (oa) seen_a = 1'b1;
         else if (ob) n_b++;
      end
      checks++;
      if (!seen_a || n_b != MAX_LOCK) begin
         failures++;
         $display("FAIL lock_timeout: got A granted=%b after %0d B grants expected 1 after %0d", seen_a, n_b, MAX_LOCK);
      end
      idle_inputs();
      cycle(oa, ob);
   endtask

   task automatic test_random();
      bit oa, ob;
      bit a_pend = 1'b0, b_pend = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!a_pend) a_req = ($urandom_range(0, 2) != 0);
         a_addr = 8'($urandom_range(0, 15));
         if (!b_pend) b_req = ($urandom_range(0, 2) != 0);
         b_we    = 1'($urandom_range(0, 1));
         b_lock  = ($urandom_range(0, 3) == 0);
         b_addr  = 8'($urandom_range(0, 15));
         b_wdata = 8'($urandom);
         cycle(oa, ob);
         a_pend = a_req && !oa;
         b_pend = b_req && !ob;
      end
      idle_inputs();
   endtask

   task automatic test_reset_midop();
      bit oa, ob;
      @(negedge clk);
      idle_inputs();
      a_req = 1; a_addr = 8'h10;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin
         failures++;
         $display("FAIL midop_grant: got a_ready=%b expected 1", a_ready);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      checks++;
      if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL midop_drop: got a_rvalid=%b b_rvalid=%b expected 0 0", a_rvalid, b_rvalid);
      end
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      checks++;
      if (a_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL midop_hold: got a_rvalid=%b expected 0", a_rvalid);
      end
      a_req = 1; a_addr = 8'h11;
      b_req = 1; b_lock = 1; b_addr = 8'h12;
      cycle(oa, ob);
      checks++;
      if (oa !== 1'b1 || ob !== 1'b0) begin
         failures++;
         $display("FAIL midop_contest: got a=%b b=%b expected a=1 b=0", oa, ob);
      end
      idle_inputs();
      cycle(oa, ob);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
      rst = 1'b0;
      idle_inputs();
      model_reset();
      test_reset();
      test_single_read();
      test_alternate();
      test_write_read();
      test_lock_rmw();
      test_lock_timeout();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
